// File: rtl/sha256_multi_if.sv
// Host and memory-port bundle for the sha256_multi core.
// The master side is the host and memory system. The slave side is the hashing core.
interface sha256_multi_if #(
  parameter int MAX_WORDS = 1024,
  parameter int ADDR_W    = 16
);
  localparam int NW_W = $clog2(MAX_WORDS + 1);

  logic              start;
  logic [NW_W-1:0]   num_words;
  logic              double_hash;
  logic [ADDR_W-1:0] message_addr;
  logic [ADDR_W-1:0] output_addr;
  logic              done;
  logic              busy;
  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  modport master (
    output start, num_words, double_hash, message_addr, output_addr, mem_read_data,
    input  done, busy, mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    input  start, num_words, double_hash, message_addr, output_addr, mem_read_data,
    output done, busy, mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/sha256_multi.sv
// SHA-256 / SHA-256d engine for run-time-sized messages.
// The message is streamed from word memory one 16-word block at a time.
// The eight-word digest is written back through the same port.
module sha256_multi #(
  parameter int MAX_WORDS = 1024,
  parameter int ADDR_W    = 16
) (
  input logic           clk,
  input logic           reset,
  sha256_multi_if.slave bus
);
  localparam int NW_W = $clog2(MAX_WORDS + 1);
  localparam int J_W  = NW_W + 1;   // block index runs up to num_blocks+1
  localparam int G_W  = J_W + 4;    // global word index {j, k}

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FINAL, WRITE} state_t;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t            state, state_next;
  logic [NW_W-1:0]   nw;
  logic              dh, second;
  logic [ADDR_W-1:0] maddr, oaddr;
  logic [J_W-1:0]    j, j_inc, nb;
  logic [6:0]        cnt;
  logic [31:0]       h [8];
  logic [31:0]       v [8];
  logic [31:0]       w [16];
  logic [3:0]        k_idx;
  logic [G_W-1:0]    g;
  logic [63:0]       bitlen;
  logic              last_block;
  logic [31:0]       w_load, w_next, t1, t2;

  // The last block is the one carrying the 64-bit length in words 14 and 15.
  assign nb         = (({1'b0, nw} + J_W'(2)) >> 4) + J_W'(1);
  assign j_inc      = j + J_W'(1);
  assign last_block = (j_inc == nb);
  assign bitlen     = 64'(nw) << 5;
  assign k_idx      = cnt[3:0] - 4'd1;   // word captured this cycle was addressed last cycle
  assign g          = {j, k_idx};

  assign t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[cnt[5:0]] + w[0];
  assign t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
  assign w_next = w[0] + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[9]
                + (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10));

  assign bus.done    = (state == IDLE);
  assign bus.busy    = ~bus.done;
  assign bus.mem_clk = clk;

  // Padding substitution: length words first, then message, then the 1-bit marker, then zeros.
  always_comb begin
    // NOTE: every branch assigns w_load, so no latch can be inferred.
    if (last_block && k_idx == 4'd14)      w_load = bitlen[63:32];
    else if (last_block && k_idx == 4'd15) w_load = bitlen[31:0];
    else if (g < G_W'(nw))                 w_load = bus.mem_read_data;
    else if (g == G_W'(nw))                w_load = 32'h8000_0000;
    else                                   w_load = '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and memory-port drive.
  always_comb begin
    // NOTE: defaults come first so that paths leaving an output unassigned do not create latches.
    state_next         = state;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    case (state)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD: begin
        bus.mem_addr = maddr + ADDR_W'({j, 4'b0000}) + ADDR_W'(cnt);
        if (cnt == 7'd16) state_next = COMPUTE;
      end
      COMPUTE: if (cnt == 7'd64) begin
        if (j_inc < nb)         state_next = LOAD;
        else if (dh && !second) state_next = FINAL;
        else                    state_next = WRITE;
      end
      FINAL:   state_next = COMPUTE;
      WRITE: begin
        bus.mem_we         = 1'b1;
        bus.mem_addr       = oaddr + ADDR_W'(cnt);
        bus.mem_write_data = h[cnt[2:0]];
        if (cnt == 7'd7) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers: request capture, per-state cycle counter, block index, pass flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      nw     <= '0;
      dh     <= 1'b0;
      second <= 1'b0;
      maddr  <= '0;
      oaddr  <= '0;
      j      <= '0;
      cnt    <= '0;
    end else begin
      if (state_next != state || state == IDLE) cnt <= '0;
      else                                      cnt <= cnt + 7'd1;
      case (state)
        IDLE: if (bus.start) begin
          nw     <= bus.num_words;
          dh     <= bus.double_hash;
          maddr  <= bus.message_addr;
          oaddr  <= bus.output_addr;
          j      <= '0;
          second <= 1'b0;
        end
        COMPUTE: if (cnt == 7'd64) j <= j_inc;
        FINAL:   second <= 1'b1;
        default: ;
      endcase
    end
  end

  // Hash datapath: schedule window, working variables a..h, chaining value H.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are not reset; each is fully loaded before it is read.
    case (state)
      IDLE: if (bus.start) for (int i = 0; i < 8; i++) h[i] <= IV[i];
      LOAD: begin
        if (cnt != 7'd0) begin
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_load;
        end
        if (cnt == 7'd16) for (int i = 0; i < 8; i++) v[i] <= h[i];
      end
      COMPUTE: begin
        if (cnt != 7'd64) begin
          v[0] <= t1 + t2;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_next;
        end else begin
          for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
        end
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) begin
          w[i] <= h[i];
          h[i] <= IV[i];
          v[i] <= IV[i];
        end
        w[8] <= 32'h8000_0000;
        for (int i = 9; i < 15; i++) w[i] <= '0;
        w[15] <= 32'h0000_0100;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/sha256_multi.md
Name: sha256_multi

Overview:
- Parametrised successor to the fixed-size SHA-256 engine.
- Hashes a message whose word count is given at run time (up to MAX_WORDS) and streams it from word-addressed memory one 16-word block at a time, so no full-message buffer is needed.
- Optional double-hash mode computes SHA256(SHA256(msg)), the Bitcoin hashing primitive.
- Writes the 8-word digest back to memory through the same memory-port style as the existing core.

Parameters:
- MAX_WORDS, 1024, largest accepted message length in 32-bit words; sets the width of num_words.
- ADDR_W, 16, memory word-address width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_words  in  $clog2(MAX_WORDS+1)  message length in words; 0 is legal.
- double_hash  in  1  1 = SHA256d, 0 = single SHA-256; sampled with start.
- message_addr  in  ADDR_W  word address of message word 0.
- output_addr  in  ADDR_W  word address for digest word H0.
- done  out  1  high while in IDLE.
- busy  out  1  equal to ~done.
- mem_clk  out  1  equal to clk.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  read data, valid 1 cycle after its address is presented.

Behaviour:
- Reset:
  - state=IDLE, mem_we=0, mem_addr=0, mem_write_data=0, done=1, busy=0.
  - Internal counters are cleared.
  - Reset asserted mid-operation aborts immediately. No further memory write occurs; any write in flight is the last one.
- Start capture: on start in IDLE, latch num_words, double_hash, message_addr, output_addr. Inputs may change afterwards. start outside IDLE is ignored.
- num_blocks = (num_words+2)/16 + 1 (integer divide), i.e. ceil((32n+65)/512).
- Length field: bitlen = 64-bit num_words*32.
- States: IDLE -> LOAD -> COMPUTE -> (LOAD | FINAL | WRITE) -> IDLE.
- At start, H0..H7 = standard IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) and block index j=0.
- LOAD (17 cycles per block):
  - Issues addresses message_addr+16j+k for k=0..15 (mem_we=0).
  - Captures w[k] one cycle later.
  - Substitution of global index g=16j+k, in priority order:
    - last block and k=14 -> bitlen[63:32];
    - last block and k=15 -> bitlen[31:0];
    - g<num_words -> memory data;
    - g==num_words -> 32'h80000000;
    - otherwise 0.
  - Addresses for g>=num_words may still be driven, but their data is discarded.
  - Address arithmetic wraps modulo 2^ADDR_W.
- COMPUTE (65 cycles per block):
  - Loads a..h from H at entry.
  - One round per cycle for t=0..63, using a 16-entry sliding schedule window.
  - For t>=16: W_t = w0 + s0(w1) + w9 + s1(w14).
  - Cycle 65 adds a..h into H0..H7 (mod 2^32) and increments j.
  - If j<num_blocks -> LOAD. Else if double_hash and first pass -> FINAL. Else -> WRITE.
- FINAL (1 cycle):
  - w[0..7] = H0..H7, w[8] = 80000000, w[9..14] = 0, w[15] = 00000100.
  - H reset to IV; sets the second-pass flag; -> COMPUTE.
  - After that block -> WRITE.
- WRITE (8 cycles): mem_we=1, mem_addr=output_addr+i, mem_write_data=H_i for i=0..7, in order. Then mem_we=0, -> IDLE.
- done rises the cycle after the last write.
- Latency start->done = 1 + num_blocks*(17+65) + double_hash*(1+65) + 8 + 1 cycles.
- Counter widths must not overflow at num_words=MAX_WORDS.
- num_words > MAX_WORDS is not permitted; behaviour is undefined.

Test Plan:
- num_words=0, double_hash=0, output_addr=0x100 -> writes e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 to 0x100..0x107. done returns after 1+82+9 = 92 cycles.
- num_words=0, double_hash=1 -> digest 5df6e0e2 761359d3 0a827505 8e299fcc 03815345 45f55cf4 3e41983f 5d4c9456.
- Block-boundary sweep num_words in {13, 14, 20, 29, 30} with random data -> num_blocks 1, 2, 2, 2, 3, confirmed via LOAD count. Digest matches the software model.
- num_words=20, double_hash=1 (Bitcoin header-sized) -> digest equals the software SHA256d model. Exactly 8 writes occur, with no writes outside output_addr..+7.
- reset pulsed during COMPUTE of block 1, then a new start with num_words=0 -> no writes before reset release. Second run gives the empty-message digest.
- start pulsed while busy, and message_addr changed after start -> both ignored; result unchanged from the unperturbed run.
